spi_flash_wb_reader: RTL and testbench

SPI_FLASH_WB_READER -- requirements
Module: spi_flash_wb_reader

---
 rtl/spi_flash_pkg.sv | 26 ++
 rtl/wb_master_single.sv | 60 ++++++
 rtl/spi_flash_wb_reader.sv | 194 +++++++++++++++++++
 tb/tb_spi_flash_wb_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash Wishbone reader.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SS_LOW,
        CMD_WR,
        CMD_RD,
        DATA_WR,
        DATA_RD,
        OUT,
        SS_HIGH
    } state_t;

    // Values written to the SPI master's chip-select config register.
    localparam logic [7:0] CFG_SS_ASSERT   = 8'h00;
    localparam logic [7:0] CFG_SS_DEASSERT = 8'h01;
    // Byte shifted out to clock in each read-data byte.
    localparam logic [7:0] DUMMY_BYTE      = 8'h00;

    // Byte sel of a 32-bit flash address (sel=0 is the least significant byte).
    function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] sel);
        return 8'(addr >> {sel, 3'b000});
    endfunction

endpackage

// File: rtl/wb_master_single.sv
// Issues one Wishbone read or write per start and pulses done with the read data.
// stb drops once accepted, cyc drops on ack; a new start is taken only while
// cyc is low, so a registered start always leaves at least one idle cycle.
module wb_master_single (
    input  logic       clk,
    input  logic       sresetn,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic [7:0] m_wb_addr,
    output logic [7:0] m_wb_dat_m2s,
    input  logic [7:0] m_wb_dat_s2m,
    output logic       m_wb_we,
    output logic       m_wb_sel,
    output logic       m_wb_stb,
    output logic       m_wb_cyc,
    input  logic       m_wb_ack,
    input  logic       m_wb_stall
);

    assign m_wb_sel = 1'b1;

    // Single-transaction handshake; ack outside cyc is ignored.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            m_wb_cyc     <= 1'b0;
            m_wb_stb     <= 1'b0;
            m_wb_we      <= 1'b0;
            m_wb_addr    <= 8'h00;
            m_wb_dat_m2s <= 8'h00;
            rdata        <= 8'h00;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!m_wb_cyc) begin
                if (start) begin
                    m_wb_cyc     <= 1'b1;
                    m_wb_stb     <= 1'b1;
                    m_wb_we      <= we;
                    m_wb_addr    <= addr;
                    m_wb_dat_m2s <= wdata;
                end
            end else begin
                if (m_wb_stb && !m_wb_stall) begin
                    m_wb_stb <= 1'b0;
                end
                if (m_wb_ack) begin
                    m_wb_cyc <= 1'b0;
                    m_wb_stb <= 1'b0;
                    rdata    <= m_wb_dat_s2m;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_wb_reader.sv
// Reads a byte range from SPI flash through a Wishbone-attached SPI master and
// streams the bytes out on AXI-Stream.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a request
// SS_LOW  | write CFG_SS_ASSERT to the config register
// CMD_WR  | write opcode (cmd_cnt=0) or address byte cmd_cnt, MSB first
// CMD_RD  | read back and discard the byte clocked in by CMD_WR
// DATA_WR | write dummy byte to clock in one flash byte
// DATA_RD | read the flash byte into axis_o_tdata
// OUT     | present the byte until the consumer takes it
// SS_HIGH | write CFG_SS_DEASSERT, then back to IDLE
import spi_flash_pkg::*;

module spi_flash_wb_reader #(
    parameter logic [7:0] READ_CMD   = 8'h03,
    parameter int         ADDR_BYTES = 3,
    parameter logic [7:0] CFG_ADDR   = 8'h01,
    parameter logic [7:0] DATA_ADDR  = 8'h02
) (
    input  logic        clk,
    input  logic        sresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  m_wb_addr,
    output logic [7:0]  m_wb_dat_m2s,
    input  logic [7:0]  m_wb_dat_s2m,
    output logic        m_wb_we,
    output logic        m_wb_sel,
    output logic        m_wb_stb,
    output logic        m_wb_cyc,
    input  logic        m_wb_ack,
    input  logic        m_wb_stall,
    input  logic        axis_o_tready,
    output logic        axis_o_tvalid,
    output logic [7:0]  axis_o_tdata,
    output logic        axis_o_tlast
);

    localparam logic [2:0] CMD_LAST = 3'(ADDR_BYTES);

    state_t      state, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_data, cnt_data_d;
    logic [2:0]  cmd_cnt, cmd_cnt_d;
    logic        launched, launched_d;
    logic        tvalid_d, tlast_d;
    logic [7:0]  tdata_d;

    logic        wb_start, wb_we, wb_done;
    logic [7:0]  wb_addr, wb_wdata, wb_rdata;
    logic        wb_phase;

    // Every state except IDLE and OUT runs exactly one WB transaction.
    assign wb_phase = (state != IDLE) && (state != OUT);

    // Next-state, request handshake and WB command selection.
    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        cnt_data_d = cnt_data;
        cmd_cnt_d  = cmd_cnt;
        launched_d = launched;
        tvalid_d   = axis_o_tvalid;
        tdata_d    = axis_o_tdata;
        tlast_d    = axis_o_tlast;
        req_ready  = 1'b0;
        wb_start   = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = DATA_ADDR;
        wb_wdata   = DUMMY_BYTE;

        // launched stops a second start for the same state before done arrives.
        if (wb_phase && !launched) begin
            wb_start   = 1'b1;
            launched_d = 1'b1;
        end
        if (wb_done) begin
            launched_d = 1'b0;
        end

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d     = req_addr;
                    cnt_data_d = req_len;
                    cmd_cnt_d  = 3'd0;
                    state_d    = SS_LOW;
                end
            end
            SS_LOW: begin
                wb_we    = 1'b1;
                wb_addr  = CFG_ADDR;
                wb_wdata = CFG_SS_ASSERT;
                if (wb_done) state_d = CMD_WR;
            end
            CMD_WR: begin
                wb_we    = 1'b1;
                wb_wdata = (cmd_cnt == 3'd0) ? READ_CMD
                                             : addr_byte(addr_q, 2'(CMD_LAST - cmd_cnt));
                if (wb_done) state_d = CMD_RD;
            end
            CMD_RD: begin
                if (wb_done) begin
                    if (cmd_cnt == CMD_LAST) begin
                        state_d = DATA_WR;
                    end else begin
                        cmd_cnt_d = cmd_cnt + 3'd1;
                        state_d   = CMD_WR;
                    end
                end
            end
            DATA_WR: begin
                wb_we = 1'b1;
                if (wb_done) state_d = DATA_RD;
            end
            DATA_RD: begin
                if (wb_done) begin
                    tdata_d  = wb_rdata;
                    tlast_d  = (cnt_data == 16'd0);
                    tvalid_d = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (axis_o_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (cnt_data == 16'd0) begin
                        state_d = SS_HIGH;
                    end else begin
                        cnt_data_d = cnt_data - 16'd1;
                        state_d    = DATA_WR;
                    end
                end
            end
            SS_HIGH: begin
                wb_we    = 1'b1;
                wb_addr  = CFG_ADDR;
                wb_wdata = CFG_SS_DEASSERT;
                if (wb_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and AXIS output registers.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state         <= IDLE;
            addr_q        <= 32'h0;
            cnt_data      <= 16'h0;
            cmd_cnt       <= 3'd0;
            launched      <= 1'b0;
            axis_o_tvalid <= 1'b0;
            axis_o_tdata  <= 8'h00;
            axis_o_tlast  <= 1'b0;
        end else begin
            state         <= state_d;
            addr_q        <= addr_d;
            cnt_data      <= cnt_data_d;
            cmd_cnt       <= cmd_cnt_d;
            launched      <= launched_d;
            axis_o_tvalid <= tvalid_d;
            axis_o_tdata  <= tdata_d;
            axis_o_tlast  <= tlast_d;
        end
    end

    wb_master_single u_wb (
        .clk          (clk),
        .sresetn      (sresetn),
        .start        (wb_start),
        .we           (wb_we),
        .addr         (wb_addr),
        .wdata        (wb_wdata),
        .rdata        (wb_rdata),
        .done         (wb_done),
        .m_wb_addr    (m_wb_addr),
        .m_wb_dat_m2s (m_wb_dat_m2s),
        .m_wb_dat_s2m (m_wb_dat_s2m),
        .m_wb_we      (m_wb_we),
        .m_wb_sel     (m_wb_sel),
        .m_wb_stb     (m_wb_stb),
        .m_wb_cyc     (m_wb_cyc),
        .m_wb_ack     (m_wb_ack),
        .m_wb_stall   (m_wb_stall)
    );

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
// Directed bench for spi_flash_wb_reader with a Wishbone SPI-master model,
// a protocol monitor and an AXIS sink.
module tb_spi_flash_wb_reader;

    localparam logic [7:0] CFG = 8'h01;
    localparam logic [7:0] DAT = 8'h02;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [15:0] req_len = 16'h0;
    logic [7:0]  m_wb_addr, m_wb_dat_m2s;
    logic [7:0]  m_wb_dat_s2m = 8'h00;
    logic        m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc;
    logic        m_wb_ack = 1'b0;
    logic        m_wb_stall = 1'b0;
    logic        axis_o_tready = 1'b1;
    logic        axis_o_tvalid, axis_o_tlast;
    logic [7:0]  axis_o_tdata;

    always #5 clk = ~clk;

    spi_flash_wb_reader dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .m_wb_addr     (m_wb_addr),
        .m_wb_dat_m2s  (m_wb_dat_m2s),
        .m_wb_dat_s2m  (m_wb_dat_s2m),
        .m_wb_we       (m_wb_we),
        .m_wb_sel      (m_wb_sel),
        .m_wb_stb      (m_wb_stb),
        .m_wb_cyc      (m_wb_cyc),
        .m_wb_ack      (m_wb_ack),
        .m_wb_stall    (m_wb_stall),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tdata  (axis_o_tdata),
        .axis_o_tlast  (axis_o_tlast)
    );

    int          total = 0;
    int          passed = 0;
    int          proto_err = 0;
    int          rd_cnt = 0;
    int          byte_cnt = 0;
    int          dcnt = 0;
    int          dly = 0;
    bit          rand_mode = 1'b0;
    bit          hold_ready = 1'b0;
    bit          pending = 1'b0;
    bit          pend_cfg01 = 1'b0;
    bit          acc_flag = 1'b0;
    logic [7:0]  pend_dat = 8'h00;
    logic [7:0]  junk;
    logic [15:0] wr_log[$];
    logic [8:0]  beat_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  exp_miso[$];
    time         acc_t[$];
    time         ack01_t[$];
    logic        prev_cyc = 1'b0, prev_stb = 1'b0, prev_stall = 1'b0, prev_ack = 1'b0;
    logic [16:0] prev_bus = 17'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Protocol monitor, AXIS sink and SPI-master slave model, all at negedge.
    always @(negedge clk) begin
        if (m_wb_sel !== 1'b1) proto_err++;
        if (m_wb_stb && !m_wb_cyc) proto_err++;
        if (prev_cyc && prev_ack && m_wb_cyc) proto_err++;
        if (!prev_cyc && m_wb_cyc && !m_wb_stb) proto_err++;
        if (prev_cyc && m_wb_cyc && ({m_wb_addr, m_wb_dat_m2s, m_wb_we} !== prev_bus)) proto_err++;
        if (prev_cyc && prev_stb && !prev_stall) acc_flag = 1'b1;
        if (!m_wb_cyc) acc_flag = 1'b0;
        else if (acc_flag && m_wb_stb) proto_err++;

        axis_o_tready = !hold_ready;
        if (axis_o_tvalid && axis_o_tready) beat_q.push_back({axis_o_tlast, axis_o_tdata});

        m_wb_ack = 1'b0;
        if (!sresetn) begin
            pending    = 1'b0;
            m_wb_stall = 1'b0;
            resp_q.delete();
        end else if (pending) begin
            if (dcnt == 0) begin
                m_wb_ack     = 1'b1;
                m_wb_dat_s2m = pend_dat;
                pending      = 1'b0;
                if (pend_cfg01) ack01_t.push_back($time);
            end else begin
                dcnt--;
            end
        end else if (m_wb_cyc && m_wb_stb) begin
            m_wb_stall = rand_mode ? 1'($urandom_range(1, 0)) : 1'b0;
            if (!m_wb_stall) begin
                pend_cfg01 = 1'b0;
                pend_dat   = 8'h00;
                if (m_wb_we) begin
                    wr_log.push_back({m_wb_addr, m_wb_dat_m2s});
                    if (m_wb_addr == CFG) begin
                        if (m_wb_dat_m2s == 8'h00) byte_cnt = 0;
                        else pend_cfg01 = 1'b1;
                    end else if (m_wb_addr == DAT) begin
                        junk = 8'hE0 | 8'(byte_cnt);
                        if (byte_cnt < 4) resp_q.push_back(junk);
                        else if (miso_q.size() > 0) resp_q.push_back(miso_q.pop_front());
                        else resp_q.push_back(8'hFF);
                        byte_cnt++;
                    end else begin
                        proto_err++;
                    end
                end else begin
                    rd_cnt++;
                    if (m_wb_addr != DAT || resp_q.size() == 0) proto_err++;
                    else pend_dat = resp_q.pop_front();
                end
                dly = rand_mode ? int'($urandom_range(5, 0)) : 0;
                if (dly == 0) begin
                    m_wb_ack     = 1'b1;
                    m_wb_dat_s2m = pend_dat;
                    if (pend_cfg01) ack01_t.push_back($time);
                end else begin
                    pending = 1'b1;
                    dcnt    = dly - 1;
                end
            end
        end else begin
            m_wb_stall = 1'b0;
        end

        prev_cyc   = m_wb_cyc;
        prev_stb   = m_wb_stb;
        prev_stall = m_wb_stall;
        prev_ack   = m_wb_ack;
        prev_bus   = {m_wb_addr, m_wb_dat_m2s, m_wb_we};
    end

    // Request acceptance times.
    always @(posedge clk) begin
        if (sresetn && req_valid && req_ready) acc_t.push_back($time);
    end

    task automatic clear_logs();
        wr_log.delete();
        beat_q.delete();
        miso_q.delete();
        exp_miso.delete();
        acc_t.delete();
        ack01_t.delete();
        rd_cnt    = 0;
        proto_err = 0;
    endtask

    task automatic load(input logic [7:0] b);
        miso_q.push_back(b);
        exp_miso.push_back(b);
    endtask

    task automatic start_req(input logic [31:0] a, input logic [15:0] l);
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hDEADBEEF;
        req_len   = 16'hFFFF;
    endtask

    task automatic wait_done(input string tag, input int nbeats);
        int n = 0;
        @(negedge clk);
        while (!(beat_q.size() >= nbeats && req_ready && !m_wb_cyc) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic check_req(input string tag, input logic [23:0] a, input int len, input int reps);
        logic [15:0] ew[$];
        logic [15:0] got;
        logic [8:0]  eb;
        int          nb;
        for (int r = 0; r < reps; r++) begin
            ew.push_back({CFG, 8'h00});
            ew.push_back({DAT, 8'h03});
            ew.push_back({DAT, a[23:16]});
            ew.push_back({DAT, a[15:8]});
            ew.push_back({DAT, a[7:0]});
            for (int i = 0; i <= len; i++) ew.push_back({DAT, 8'h00});
            ew.push_back({CFG, 8'h01});
        end
        chk($sformatf("%s_nwr", tag), 32'(wr_log.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 16'hXXXX;
            chk($sformatf("%s_wr%0d", tag, i), 32'(got), 32'(ew[i]));
        end
        nb = reps * (len + 1);
        chk($sformatf("%s_nbeat", tag), 32'(beat_q.size()), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            eb  = {(i % (len + 1)) == len, exp_miso[i]};
            got = (i < beat_q.size()) ? {7'h0, beat_q[i]} : 16'hXXXX;
            chk($sformatf("%s_beat%0d", tag, i), 32'(got), 32'(eb));
        end
        chk($sformatf("%s_nrd", tag), 32'(rd_cnt), 32'(reps * (len + 5)));
        chk($sformatf("%s_proto", tag), 32'(proto_err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_cyc"}, 32'(m_wb_cyc), 32'd0);
        chk({tag, "_stb"}, 32'(m_wb_stb), 32'd0);
        chk({tag, "_we"}, 32'(m_wb_we), 32'd0);
        chk({tag, "_addr"}, 32'(m_wb_addr), 32'd0);
        chk({tag, "_dat"}, 32'(m_wb_dat_m2s), 32'd0);
        chk({tag, "_tvalid"}, 32'(axis_o_tvalid), 32'd0);
        chk({tag, "_tlast"}, 32'(axis_o_tlast), 32'd0);
        chk({tag, "_tdata"}, 32'(axis_o_tdata), 32'd0);
        chk({tag, "_sel"}, 32'(m_wb_sel), 32'd1);
    endtask

    initial begin
        int          n;
        int          bad;
        logic [8:0]  snap;

        sresetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        sresetn = 1'b1;
        @(negedge clk);

        // Single byte, no stall.
        clear_logs();
        load(8'hA5);
        start_req(32'h00123456, 16'd0);
        wait_done("t1", 1);
        check_req("t1", 24'h123456, 0, 1);

        // Four bytes; top address byte must be ignored.
        clear_logs();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        start_req(32'h77ABCDEF, 16'd3);
        wait_done("t2", 4);
        check_req("t2", 24'hABCDEF, 3, 1);

        // Random stall and ack delay.
        rand_mode = 1'b1;
        clear_logs();
        load(8'h3C); load(8'hC3); load(8'h00); load(8'hFF); load(8'h81);
        start_req(32'h00010203, 16'd4);
        wait_done("t3", 5);
        check_req("t3", 24'h010203, 4, 1);
        rand_mode = 1'b0;

        // Consumer back-pressure for 20 cycles mid-stream.
        clear_logs();
        load(8'h01); load(8'h02); load(8'h03); load(8'h04); load(8'h05); load(8'h06);
        start_req(32'h00445566, 16'd5);
        n = 0;
        while (beat_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
        hold_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!axis_o_tvalid && n < 2000) begin @(negedge clk); n++; end
        chk("t4_tvalid_seen", 32'(axis_o_tvalid), 32'd1);
        snap = {axis_o_tlast, axis_o_tdata};
        bad  = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_wb_cyc || !axis_o_tvalid || ({axis_o_tlast, axis_o_tdata} !== snap)) bad++;
        end
        chk("t4_hold_stable", 32'(bad), 32'd0);
        hold_ready = 1'b0;
        wait_done("t4", 6);
        check_req("t4", 24'h445566, 5, 1);

        // Reset during the second DATA_RD, then a fresh request.
        clear_logs();
        load(8'h5A); load(8'h6B); load(8'h7C); load(8'h8D);
        start_req(32'h000A0B0C, 16'd3);
        n = 0;
        while (!(wr_log.size() >= 7 && m_wb_cyc && !m_wb_we) && n < 2000) begin @(negedge clk); n++; end
        chk("t5_in_data_rd", 32'(m_wb_cyc && !m_wb_we), 32'd1);
        sresetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        @(negedge clk);
        sresetn = 1'b1;
        @(negedge clk);
        clear_logs();
        load(8'h99); load(8'h66);
        start_req(32'h00FEDCBA, 16'd1);
        wait_done("t5b", 2);
        check_req("t5b", 24'hFEDCBA, 1, 1);

        // req_valid held high across two requests.
        clear_logs();
        load(8'h10); load(8'h20); load(8'h30); load(8'h40);
        req_addr  = 32'h00C0FFEE;
        req_len   = 16'd1;
        req_valid = 1'b1;
        n = 0;
        while (acc_t.size() < 2 && n < 5000) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        wait_done("t6", 4);
        check_req("t6", 24'hC0FFEE, 1, 2);
        chk("t6_nacc", 32'(acc_t.size()), 32'd2);
        chk("t6_order", 32'(acc_t.size() >= 2 && ack01_t.size() >= 1 && acc_t[1] > ack01_t[0]), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
